// File: rtl/hand_slave_rx.sv
// hand_slave_rx: receive side of the ven/rdy bus handshake.
// Bus beats are accepted into a small first-word-fall-through FIFO. The FIFO
// drains to local logic under ren. A monitor flags bus beats that drop ven or
// change data_b before they are accepted. A free-running counter tracks the
// number of accepted beats.
module hand_slave_rx #(
    parameter int L     = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int CW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ven,
    input  logic [L-1:0]  data_b,
    output logic          rdy,
    input  logic          ren,
    output logic [L-1:0]  data_out,
    output logic          vout,
    output logic [AW:0]   count,
    output logic [CW-1:0] beat_cnt,
    output logic          proto_err
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic {
        MON_IDLE = 1'b0,
        MON_WAIT = 1'b1
    } mon_state_t;

    logic [L-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic [CW-1:0] beat_cnt_reg;
    logic          proto_err_reg;

    mon_state_t    state_reg;
    mon_state_t    state_next;
    logic [L-1:0]  hold_reg;
    logic [L-1:0]  hold_next;
    logic          err_set;

    logic          push;
    logic          pop;

    // Ready and valid depend only on registered occupancy and reset. There is
    // deliberately no combinational path from ven to rdy, and no
    // full-and-popping bypass.
    assign rdy  = !rst && (count_reg != FULL_CNT);
    assign vout = !rst && (count_reg != '0);
    assign push = ven && rdy;
    assign pop  = ren && vout;

    assign data_out  = mem[rd_ptr_reg];
    assign count     = count_reg;
    assign beat_cnt  = beat_cnt_reg;
    assign proto_err = proto_err_reg;

    // FIFO storage. This array is not cleared by reset. Stale contents are
    // hidden because vout is low.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= data_b;
        end
    end

    // Pointers, occupancy and the accepted-beat counter. Pointers wrap
    // naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            beat_cnt_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg   <= wr_ptr_reg + 1'b1;
                beat_cnt_reg <= beat_cnt_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop && !push) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    // Monitor next state. Once a beat is stalled by rdy=0, it must keep ven
    // high and data_b stable until it is accepted.
    always_comb begin
        state_next = state_reg;
        hold_next  = hold_reg;
        err_set    = 1'b0;
        case (state_reg)
            MON_IDLE: begin
                if (ven && !rdy) begin
                    hold_next  = data_b;
                    state_next = MON_WAIT;
                end
            end
            MON_WAIT: begin
                if (!ven || (data_b != hold_reg)) begin
                    err_set    = 1'b1;
                    state_next = MON_IDLE;
                end else if (rdy) begin
                    state_next = MON_IDLE;
                end
            end
            default: state_next = MON_IDLE;
        endcase
    end

    // Monitor state register and sticky error flag. Only reset clears the flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= MON_IDLE;
            hold_reg      <= '0;
            proto_err_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            hold_reg  <= hold_next;
            if (err_set) begin
                proto_err_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hand_slave_rx.sv
// Directed testbench for hand_slave_rx. It uses the default parameters:
// L=8, DEPTH=4, AW=2 and CW=16.
module tb_hand_slave_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ven = 1'b0;
    logic [7:0]  data_b = 8'h00;
    logic        rdy;
    logic        ren = 1'b0;
    logic [7:0]  data_out;
    logic        vout;
    logic [2:0]  count;
    logic [15:0] beat_cnt;
    logic        proto_err;

    int n_checks = 0;
    int n_fail   = 0;

    hand_slave_rx #(.L(8), .DEPTH(4), .AW(2), .CW(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .ven      (ven),
        .data_b   (data_b),
        .rdy      (rdy),
        .ren      (ren),
        .data_out (data_out),
        .vout     (vout),
        .count    (count),
        .beat_cnt (beat_cnt),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    // Advance one edge. Afterwards, inputs may be driven and outputs checked,
    // well away from the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_beat(input logic [7:0] d);
        ven    = 1'b1;
        data_b = d;
        tick();
        ven    = 1'b0;
    endtask

    initial begin
        logic [7:0] stream [4];
        logic [7:0] drain [4];
        logic [7:0] beats [10];
        logic [7:0] q[$];
        logic [7:0] exp_d;
        int sent;
        int got;

        stream = '{8'h56, 8'ha8, 8'h37, 8'hbe};
        drain  = '{8'ha8, 8'hf7, 8'hce, 8'h22};
        for (int i = 0; i < 10; i++) beats[i] = 8'(8'h10 + i * 8'h13);

        // 1: reset, then idle
        tick();
        tick();
        check("rst_rdy", rdy, 0);
        check("rst_vout", vout, 0);
        check("rst_count", count, 0);
        check("rst_beat_cnt", beat_cnt, 0);
        check("rst_proto_err", proto_err, 0);
        rst = 1'b0;
        #1;
        check("post_rst_rdy", rdy, 1);
        $display("step 1 reset done: rdy=%0b count=%0d", rdy, count);

        // 2: streaming with ren held high
        ren = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ven    = 1'b1;
            data_b = stream[k];
            tick();
            check("stream_data", data_out, stream[k]);
            check("stream_vout", vout, 1);
            check("stream_count", count, 1);
            $display("stream beat %0d: data_out=%h count=%0d", k, data_out, count);
        end
        ven = 1'b0;
        tick();
        ren = 1'b0;
        check("stream_empty", count, 0);
        check("stream_beat_cnt", beat_cnt, 4);

        // 3: fill to full, hold a stalled beat, free one slot, then drain
        push_beat(8'h33);
        push_beat(8'ha8);
        push_beat(8'hf7);
        push_beat(8'hce);
        check("full_count", count, 4);
        check("full_rdy", rdy, 0);
        ven    = 1'b1;
        data_b = 8'h22;
        tick();
        tick();
        check("full_hold_count", count, 4);
        check("full_hold_err", proto_err, 0);
        check("full_head", data_out, 8'h33);
        ren = 1'b1;
        tick();
        ren = 1'b0;
        check("pop_count", count, 3);
        check("pop_rdy_next", rdy, 1);
        tick();
        ven = 1'b0;
        check("refill_count", count, 4);
        check("refill_err", proto_err, 0);
        check("refill_beat_cnt", beat_cnt, 9);
        ren = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("drain_data", data_out, drain[k]);
            $display("drain beat %0d: data_out=%h", k, data_out);
            tick();
        end
        ren = 1'b0;
        check("drain_vout", vout, 0);
        check("drain_count", count, 0);

        // 4: ten beats with ren alternating, to exercise pointer wrap
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 80 && got < 10; cyc++) begin
            ven    = (sent < 10);
            data_b = (sent < 10) ? beats[sent] : 8'h00;
            ren    = cyc[0];
            #1;
            if (ren && vout) begin
                exp_d = q.pop_front();
                check("wrap_data", data_out, exp_d);
                $display("wrap pop %0d: data_out=%h expected=%h", got, data_out, exp_d);
                got++;
            end
            if (ven && rdy) begin
                q.push_back(data_b);
                sent++;
            end
            tick();
        end
        ven = 1'b0;
        ren = 1'b0;
        check("wrap_received", got, 10);
        check("wrap_count", count, 0);
        check("wrap_err", proto_err, 0);

        // 5a: ven drops while the beat is stalled
        for (int k = 0; k < 4; k++) push_beat(8'h40 + 8'(k));
        ven    = 1'b1;
        data_b = 8'hbe;
        tick();
        check("drop_pre_err", proto_err, 0);
        ven = 1'b0;
        tick();
        check("drop_err", proto_err, 1);
        tick();
        tick();
        check("drop_err_sticky", proto_err, 1);
        $display("proto case 1: proto_err=%0b", proto_err);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("clear_err", proto_err, 0);

        // 5b: data changes while the beat is stalled
        for (int k = 0; k < 4; k++) push_beat(8'h60 + 8'(k));
        ven    = 1'b1;
        data_b = 8'hbe;
        tick();
        check("chg_pre_err", proto_err, 0);
        data_b = 8'h33;
        tick();
        ven = 1'b0;
        check("chg_err", proto_err, 1);
        $display("proto case 2: proto_err=%0b", proto_err);

        // 6: reset mid-operation with three stored beats
        ren = 1'b1;
        tick();
        ren = 1'b0;
        check("pre_rst_count", count, 3);
        rst = 1'b1;
        #1;
        check("in_rst_rdy", rdy, 0);
        check("in_rst_vout", vout, 0);
        tick();
        check("mid_rst_count", count, 0);
        check("mid_rst_beat_cnt", beat_cnt, 0);
        check("mid_rst_err", proto_err, 0);
        rst = 1'b0;
        push_beat(8'h5a);
        check("after_rst_data", data_out, 8'h5a);
        check("after_rst_vout", vout, 1);
        check("after_rst_beat_cnt", beat_cnt, 1);
        $display("reset mid-op: first beat out=%h", data_out);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
